// File: rtl/river_move_ctrl.sv
// Move sequencer for the farmer/fox/chicken/seed puzzle: turns move requests into
// bank positions, waits for the puzzle to settle, then records its verdict.
module river_move_ctrl #(
    parameter int SETTLE    = 2,
    parameter int MAX_MOVES = 15,
    parameter int MW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [1:0]    sel,
    input  logic          clr,
    input  logic          win,
    input  logic          lose,
    input  logic          inv,
    output logic [3:0]    pos,
    output logic          busy,
    output logic          done,
    output logic [1:0]    result,
    output logic [MW-1:0] moves,
    output logic          rej
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(SETTLE - 1);
    localparam logic [MW-1:0] MOVE_LIMIT = MW'(MAX_MOVES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_EVAL = 3'd2,
        S_WON  = 3'd3,
        S_LOST = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pos_q, pos_d;
    logic [3:0]    saved_q, saved_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [MW-1:0] moves_q, moves_d;
    logic [1:0]    result_q, result_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rej_q, rej_d;

    logic          pass_bit;
    logic [3:0]    flip_mask;
    logic [MW-1:0] moves_inc;

    always_comb begin
        pass_bit = 1'b0;
        case (sel)
            2'd1:    pass_bit = pos_q[2];
            2'd2:    pass_bit = pos_q[1];
            2'd3:    pass_bit = pos_q[0];
            default: pass_bit = pos_q[3];
        endcase
        flip_mask = {1'b1, sel == 2'd1, sel == 2'd2, sel == 2'd3};
        moves_inc = moves_q + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        saved_d  = saved_q;
        wcnt_d   = wcnt_q;
        moves_d  = moves_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        rej_d    = 1'b0;

        if (clr) begin
            state_d  = S_IDLE;
            pos_d    = 4'b0000;
            saved_d  = 4'b0000;
            wcnt_d   = '0;
            moves_d  = '0;
            result_d = 2'b00;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        // A passenger can only cross from the bank the farmer stands on.
                        if (sel != 2'd0 && pass_bit != pos_q[3]) begin
                            rej_d = 1'b1;
                        end else begin
                            saved_d = pos_q;
                            pos_d   = pos_q ^ flip_mask;
                            wcnt_d  = '0;
                            busy_d  = 1'b1;
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WAIT_LAST) begin
                        state_d = S_EVAL;
                    end
                end
                S_EVAL: begin
                    busy_d = 1'b0;
                    if (lose) begin
                        moves_d  = moves_inc;
                        result_d = 2'b10;
                        done_d   = 1'b1;
                        state_d  = S_LOST;
                    end else if (win) begin
                        moves_d  = moves_inc;
                        result_d = 2'b01;
                        done_d   = 1'b1;
                        state_d  = S_WON;
                    end else if (inv) begin
                        pos_d   = saved_q;
                        rej_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        moves_d = moves_inc;
                        if (moves_inc == MOVE_LIMIT) begin
                            result_d = 2'b11;
                            done_d   = 1'b1;
                            state_d  = S_LOST;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_WON, S_LOST: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pos_q    <= 4'b0000;
            saved_q  <= 4'b0000;
            wcnt_q   <= '0;
            moves_q  <= '0;
            result_q <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            saved_q  <= saved_d;
            wcnt_q   <= wcnt_d;
            moves_q  <= moves_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rej_q    <= rej_d;
        end
    end

    assign pos    = pos_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign moves  = moves_q;
    assign rej    = rej_q;

endmodule

// File: tb/tb_river_move_ctrl.sv
// Bench for river_move_ctrl: a small puzzle model answers each move, and the
// expected post-move snapshot is queued at launch and checked when the move completes.
module tb_river_move_ctrl;
  localparam int SETTLE    = 4;
  localparam int MAX_MOVES = 15;
  localparam int MW        = 8;
  localparam int W         = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [1:0]    sel;
  logic          clr;
  logic          win;
  logic          lose;
  logic          inv;
  logic [3:0]    pos;
  logic          busy;
  logic          done;
  logic [1:0]    result;
  logic [MW-1:0] moves;
  logic          rej;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Puzzle response mode: 0 = real puzzle rules, 1 = silent, 2 = invalid, 3 = lose
  logic [1:0]    mode = 2'd1;
  logic [3:0]    m_pos;
  logic [MW-1:0] m_moves;

  river_move_ctrl #(.SETTLE(SETTLE), .MAX_MOVES(MAX_MOVES), .MW(MW)) dut (
    .clk(clk), .reset(reset), .go(go), .sel(sel), .clr(clr),
    .win(win), .lose(lose), .inv(inv),
    .pos(pos), .busy(busy), .done(done), .result(result),
    .moves(moves), .rej(rej)
  );

  always #5 clk = ~clk;

  function automatic logic unsafe(input logic [3:0] p);
    return ((p[2] == p[1]) && (p[3] != p[1])) || ((p[1] == p[0]) && (p[3] != p[1]));
  endfunction

  assign lose = (mode == 2'd0) ? unsafe(pos) : (mode == 2'd3);
  assign win  = (mode == 2'd0) && (pos == 4'hF);
  assign inv  = (mode == 2'd2);

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr     = 1'b0;
    m_pos   = 4'b0000;
    m_moves = '0;
    mode    = 2'd1;
  endtask

  task automatic do_move(input logic [1:0] s, input logic [1:0] m);
    logic [3:0]   np;
    logic         l, w, iv, erj, ed;
    logic [1:0]   er;
    logic [W-1:0] exp_v, got_v;
    int n;
    np  = m_pos ^ {1'b1, s == 2'd1, s == 2'd2, s == 2'd3};
    l   = (m == 2'd0) ? unsafe(np) : (m == 2'd3);
    w   = (m == 2'd0) && (np == 4'hF);
    iv  = (m == 2'd2);
    erj = 1'b0; er = 2'b00; ed = 1'b0;
    if (l) begin
      m_moves = m_moves + 1'b1; m_pos = np; er = 2'b10; ed = 1'b1;
    end else if (w) begin
      m_moves = m_moves + 1'b1; m_pos = np; er = 2'b01; ed = 1'b1;
    end else if (iv) begin
      erj = 1'b1;
    end else begin
      m_moves = m_moves + 1'b1; m_pos = np;
      if (int'(m_moves) == MAX_MOVES) begin er = 2'b11; ed = 1'b1; end
    end
    exp_q.push_back({m_pos, er, m_moves, ed});

    mode = m; sel = s; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (pos !== np || busy !== 1'b1) begin
      failures++;
      $display("FAIL move_launch: pos=%b busy=%b required pos=%b busy=1", pos, busy, np);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != SETTLE + 1) begin
      failures++;
      $display("FAIL move_latency: cycles=%0d required=%0d", n, SETTLE + 1);
    end
    exp_v = exp_q.pop_front();
    got_v = {pos, result, moves, done};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL move_outcome: pos/result/moves/done=%b/%b/%0d/%b required %b/%b/%0d/%b",
               got_v[14:11], got_v[10:9], got_v[8:1], got_v[0],
               exp_v[14:11], exp_v[10:9], exp_v[8:1], exp_v[0]);
    end
    checks++;
    if (rej !== erj) begin
      failures++;
      $display("FAIL move_rej: rej=%b required=%b", rej, erj);
    end
    if (erj) begin
      @(negedge clk);
      checks++;
      if (rej !== 1'b0) begin
        failures++;
        $display("FAIL rej_pulse_width: rej=%b required=0", rej);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; go = 1'b0; clr = 1'b0; sel = 2'd0; mode = 2'd1;
    #12;
    checks++;
    if ({pos, busy, done, result, moves, rej} !== '0) begin
      failures++;
      $display("FAIL reset_state: pos=%b busy=%b done=%b result=%b moves=%0d rej=%b required all 0",
               pos, busy, done, result, moves, rej);
    end
    @(negedge clk);
    reset   = 1'b1;
    m_pos   = 4'b0000;
    m_moves = '0;
  endtask

  task automatic test_win();
    logic [1:0] seq[7];
    logic [3:0] tbl[7];
    seq = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    tbl = '{4'b1010, 4'b0010, 4'b1110, 4'b0100, 4'b1101, 4'b0101, 4'b1111};
    do_clr();
    for (int i = 0; i < 7; i++) begin
      do_move(seq[i], 2'd0);
      checks++;
      if (pos !== tbl[i]) begin
        failures++;
        $display("FAIL win_step%0d: pos=%b required=%b", i, pos, tbl[i]);
      end
    end
    checks++;
    if (result !== 2'b01 || done !== 1'b1 || moves !== 8'd7) begin
      failures++;
      $display("FAIL win_final: result=%b done=%b moves=%0d required 01/1/7", result, done, moves);
    end
  endtask

  task automatic test_clr_won();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if ({pos, busy, done, result, moves, rej} !== '0) begin
      failures++;
      $display("FAIL clr_in_won: pos=%b busy=%b done=%b result=%b moves=%0d rej=%b required all 0",
               pos, busy, done, result, moves, rej);
    end
    m_pos = 4'b0000; m_moves = '0;
  endtask

  task automatic test_lose_ignore();
    do_clr();
    do_move(2'd0, 2'd0);
    checks++;
    if (pos !== 4'b1000 || result !== 2'b10 || done !== 1'b1 || moves !== 8'd1) begin
      failures++;
      $display("FAIL first_lose: pos=%b result=%b done=%b moves=%0d required 1000/10/1/1",
               pos, result, done, moves);
    end
    sel = 2'd2; go = 1'b1;
    repeat (8) @(negedge clk);
    go = 1'b0;
    checks++;
    if (pos !== 4'b1000 || moves !== 8'd1 || busy !== 1'b0 || done !== 1'b1 || result !== 2'b10) begin
      failures++;
      $display("FAIL go_after_lose: pos=%b moves=%0d busy=%b done=%b result=%b required 1000/1/0/1/10",
               pos, moves, busy, done, result);
    end
  endtask

  task automatic test_reject();
    do_clr();
    do_move(2'd2, 2'd1);
    sel = 2'd1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (rej !== 1'b1 || pos !== 4'b1010 || busy !== 1'b0 || moves !== 8'd1) begin
      failures++;
      $display("FAIL reject_pulse: rej=%b pos=%b busy=%b moves=%0d required 1/1010/0/1",
               rej, pos, busy, moves);
    end
    @(negedge clk);
    checks++;
    if (rej !== 1'b0 || pos !== 4'b1010 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reject_after: rej=%b pos=%b busy=%b required 0/1010/0", rej, pos, busy);
    end
  endtask

  task automatic test_inv();
    do_clr();
    do_move(2'd2, 2'd2);
    checks++;
    if (pos !== 4'b0000 || moves !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL inv_restore: pos=%b moves=%0d busy=%b done=%b required 0000/0/0/0",
               pos, moves, busy, done);
    end
    do_move(2'd2, 2'd1);
    checks++;
    if (pos !== 4'b1010 || moves !== 8'd1) begin
      failures++;
      $display("FAIL inv_then_move: pos=%b moves=%0d required 1010/1", pos, moves);
    end
  endtask

  task automatic test_timeout();
    do_clr();
    for (int i = 0; i < MAX_MOVES; i++) begin
      do_move(2'd2, 2'd1);
      if (i == MAX_MOVES - 2) begin
        checks++;
        if (result !== 2'b00 || done !== 1'b0) begin
          failures++;
          $display("FAIL before_timeout: result=%b done=%b required 00/0", result, done);
        end
      end
    end
    checks++;
    if (result !== 2'b11 || done !== 1'b1 || moves !== 8'(MAX_MOVES)) begin
      failures++;
      $display("FAIL timeout: result=%b done=%b moves=%0d required 11/1/%0d",
               result, done, moves, MAX_MOVES);
    end
  endtask

  task automatic test_final_lose();
    do_clr();
    for (int i = 0; i < MAX_MOVES - 1; i++) do_move(2'd2, 2'd1);
    do_move(2'd2, 2'd3);
    checks++;
    if (result !== 2'b10 || done !== 1'b1 || moves !== 8'(MAX_MOVES)) begin
      failures++;
      $display("FAIL lose_beats_timeout: result=%b done=%b moves=%0d required 10/1/%0d",
               result, done, moves, MAX_MOVES);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] prev;
    int t0, t1, n;
    do_clr();
    t0 = -1; t1 = -1;
    prev = pos;
    sel = 2'd2; go = 1'b1;
    for (int c = 0; c < 40 && t1 < 0; c++) begin
      @(negedge clk);
      if (pos !== prev) begin
        if (t0 < 0) t0 = c; else t1 = c;
        prev = pos;
      end
    end
    go = 1'b0;
    checks++;
    if (t1 < 0 || t1 - t0 != SETTLE + 2) begin
      failures++;
      $display("FAIL back_to_back_gap: gap=%0d required=%0d", t1 - t0, SETTLE + 2);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (moves !== 8'd2 || pos !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_end: moves=%0d pos=%b busy=%b required 2/0000/0", moves, pos, busy);
    end
  endtask

  task automatic test_reset_midwait();
    do_clr();
    do_move(2'd2, 2'd1);
    sel = 2'd0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pos !== 4'b0000 || busy !== 1'b0 || moves !== 8'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_midwait: pos=%b busy=%b moves=%0d done=%b required 0000/0/0/0",
               pos, busy, moves, done);
    end
    @(negedge clk);
    reset = 1'b1;
    m_pos = 4'b0000; m_moves = '0;
  endtask

  initial begin
    test_reset();
    test_win();
    test_clr_won();
    test_lose_ignore();
    test_reject();
    test_inv();
    test_timeout();
    test_final_lose();
    test_back_to_back();
    test_reset_midwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/river_move_ctrl.md
Name: river_move_ctrl

Overview:
Move sequencer for the farmer/fox/chicken/seed puzzle FSM. It converts player move requests (which passenger, if any, crosses with the farmer) into the 4-bit bank-position vector {farmer,fox,chicken,seed} that the puzzle FSM consumes. It waits a fixed settle time, samples the puzzle's win/lose/inv response, and tracks move count, result and timeout. It sits between the user-input logic and the puzzle FSM and is the only driver of the puzzle's position inputs.

Parameters:
SETTLE, 2, cycles held in WAIT before sampling puzzle response; legal range >= 1
MAX_MOVES, 15, move count at which an unfinished game is declared lost by timeout; legal range 1..2^MW-1
MW, 8, width of move counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
go  input  1  move request, level-sampled in IDLE only
sel  input  2  passenger: 0=farmer alone, 1=fox, 2=chicken, 3=seed
clr  input  1  synchronous new-game request
win  input  1  puzzle FSM win flag
lose  input  1  puzzle FSM lose flag
inv  input  1  puzzle FSM invalid-move flag
pos  output  4  {farmer,fox,chicken,seed}; 0=start bank, 1=far bank
busy  output  1  move in flight (WAIT or EVAL)
done  output  1  game over (WON or LOST)
result  output  2  00 none, 01 win, 10 lose, 11 timeout
moves  output  MW  accepted move count
rej  output  1  one-cycle pulse: move rejected

Behaviour:
- Reset (reset=0, async): state=IDLE; pos=0000, moves=0, result=00, busy=0, done=0, rej=0, internal wait counter=0, saved position=0000. Takes effect immediately from any state, including mid-WAIT.
- States: IDLE, WAIT, EVAL, WON, LOST. All outputs are registered.
- clr=1 at an edge in any state: same effect as reset, applied synchronously. Has priority over go.
- IDLE, go=1 at edge t:
  - Local legality: sel!=0 and pos[passenger] != pos[3] -> rej=1 for the cycle after t; pos and moves unchanged; stay IDLE.
  - Otherwise: save current pos; flip pos[3]; if sel!=0, flip the selected bit (fox=bit2, chicken=bit1, seed=bit0). New pos is visible after t. Clear wait counter; go to WAIT; busy=1.
- go is ignored outside IDLE. Held go issues one move per IDLE visit, i.e. back-to-back moves every SETTLE+2 cycles.
- WAIT: wait counter increments each cycle. After exactly SETTLE cycles in WAIT, go to EVAL.
- EVAL (one cycle): sample the inputs at its closing edge, in priority order lose > win > inv.
  - lose: moves+1; result=10; go to LOST.
  - win: moves+1; result=01; go to WON.
  - inv: restore saved pos; rej=1 for one cycle; moves unchanged; go to IDLE.
  - none: moves+1. If the new count == MAX_MOVES, result=11 and go to LOST; else go to IDLE.
  - Win/lose on the final allowed move takes precedence over timeout.
- busy=1 in WAIT and EVAL only. Results are visible SETTLE+1 cycles after the go-accept edge.
- WON/LOST: done=1, busy=0. pos, moves and result are frozen. Only clr or reset exit.
- moves never wraps; it stops at MAX_MOVES via timeout.
- win/lose/inv are ignored in every state except EVAL.

Test Plan:
- Winning sequence, sel = 2,0,1,2,3,0,2 with a bench puzzle model -> pos steps 1010,0010,1110,0100,1101,0101,1111; then result=01, done=1, moves=7.
- First move sel=0 from 0000 -> pos=1000, model asserts lose -> result=10, done=1, moves=1; a further go is ignored.
- From pos=1010 (IDLE), go with sel=1 -> rej pulses exactly 1 cycle, pos stays 1010, moves unchanged, busy stays 0.
- Model asserts inv in EVAL after a 0000 -> 1010 move -> pos restored to 0000, rej 1-cycle pulse, moves=0, state IDLE.
- MAX_MOVES=3, sel=2,2,2 with the model giving no flags -> after the third EVAL, result=11, done=1, moves=3.
- reset driven low mid-WAIT (SETTLE=4, cycle 2) -> pos=0000, busy=0, moves=0 immediately, without waiting for a clock edge. clr in WON -> IDLE with all outputs at reset values on the next edge.
